uart_tx_frame: RTL

//   Parametrised UART transmitter; next generation of the fixed 8N1 Tx.

---
 rtl/uart_tx_frame.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Configurable data width, runtime parity (none/even/odd), 1 or 2 stop bits,
// internal baud divider and gap-free back-to-back frames from an AXI-Stream source.
// Data, divisor, parity mode and stop-bit count are captured on accept, so the
// configuration inputs may change freely while a frame is on the line.

module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] s_axis_data,
    input  logic                 s_axis_valid,
    output logic                 s_axis_ready,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Current frame state and the configuration captured at accept.
    logic [2:0]           state,      nxt_state;
    logic [DIV_W-1:0]     timer,      nxt_timer;
    logic [IDX_W-1:0]     idx,        nxt_idx;
    logic                 stop_extra, nxt_stop_extra;  // another stop bit follows the current one
    logic [DATA_BITS-1:0] data_q,     nxt_data;
    logic [DIV_W-1:0]     div_q,      nxt_div;
    logic [1:0]           par_q,      nxt_par;
    logic                 stop2_q,    nxt_stop2;

    logic accept;
    logic frame_end;
    logic par_en;
    logic tx_d;
    logic frame_done_d;

    // Ready depends only on registered state (and reset), never on s_axis_valid.
    always_comb begin
        frame_end    = (state == ST_STOP) && (timer == '0) && !stop_extra;
        s_axis_ready = !i_rst && ((state == ST_IDLE) || frame_end);
        accept       = s_axis_valid && s_axis_ready;
        par_en       = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    end

    // Next-state logic: bit timer, bit index, stop-bit bookkeeping and capture on accept.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        nxt_state      = state;
        nxt_timer      = timer;
        nxt_idx        = idx;
        nxt_stop_extra = stop_extra;
        nxt_data       = data_q;
        nxt_div        = div_q;
        nxt_par        = par_q;
        nxt_stop2      = stop2_q;

        if (accept) begin
            nxt_data       = s_axis_data;
            nxt_div        = cfg_div;
            nxt_par        = cfg_parity;
            nxt_stop2      = cfg_stop2;
            nxt_state      = ST_START;
            nxt_timer      = cfg_div;
            nxt_idx        = '0;
            nxt_stop_extra = 1'b0;
        end else if (state != ST_IDLE) begin
            if (timer != '0) begin
                nxt_timer = timer - 1'b1;
            end else begin
                nxt_timer = div_q;
                case (state)
                    ST_START: begin
                        nxt_state = ST_DATA;
                        nxt_idx   = '0;
                    end
                    ST_DATA: begin
                        if (idx == LAST_IDX) begin
                            nxt_state      = par_en ? ST_PARITY : ST_STOP;
                            nxt_stop_extra = stop2_q;
                        end else begin
                            nxt_idx = idx + 1'b1;
                        end
                    end
                    ST_PARITY: nxt_state = ST_STOP;
                    ST_STOP: begin
                        if (stop_extra) begin
                            nxt_stop_extra = 1'b0;
                        end else begin
                            nxt_state = ST_IDLE;
                            nxt_timer = '0;
                        end
                    end
                    default: begin
                        nxt_state = ST_IDLE;
                        nxt_timer = '0;
                    end
                endcase
            end
        end
    end

    // Line level and frame-end flag for the upcoming cycle, so the outputs can be registered.
    always_comb begin
        case (nxt_state)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = nxt_data[nxt_idx];
            ST_PARITY: tx_d = (nxt_par == PAR_ODD) ? ~^nxt_data : ^nxt_data;
            default:   tx_d = 1'b1;
        endcase
        frame_done_d = (nxt_state == ST_STOP) && (nxt_timer == '0) && !nxt_stop_extra;
    end

    // State, captured configuration and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the captured word/config are reset too; they are a handful of flops, not a memory.
            state      <= ST_IDLE;
            timer      <= '0;
            idx        <= '0;
            stop_extra <= 1'b0;
            data_q     <= '0;
            div_q      <= '0;
            par_q      <= '0;
            stop2_q    <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= nxt_state;
            timer      <= nxt_timer;
            idx        <= nxt_idx;
            stop_extra <= nxt_stop_extra;
            data_q     <= nxt_data;
            div_q      <= nxt_div;
            par_q      <= nxt_par;
            stop2_q    <= nxt_stop2;
            tx         <= tx_d;
            busy       <= (nxt_state != ST_IDLE);
            frame_done <= frame_done_d;
        end
    end

endmodule
